dat_chunk_tx: RTL and testbench

DAT_CHUNK_TX -- requirements
Module: dat_chunk_tx

---
 rtl/dat_chunk_tx_pkg.sv | 31 +++
 rtl/dat_chunk_slice_pack.sv | 31 +++
 rtl/dat_chunk_tx.sv | 210 +++++++++++++++++++++
 tb/tb_dat_chunk_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dat_chunk_tx_pkg.sv
// Shared definitions for the sparse chunk transmitter: chunk/bus geometry,
// beat count, counter widths and the transmitter FSM state encoding.
// MEM_SIZE / BUS_SIZE (bytes) default to 512 / 128 unless defined by the build.

`ifndef MEM_SIZE
`define MEM_SIZE 512
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 128
`endif

package dat_chunk_tx_pkg;

    localparam int unsigned MEM_BYTES = `MEM_SIZE;
    localparam int unsigned BUS_BYTES = `BUS_SIZE;

    // Write beats per chunk; MEM_SIZE is a multiple of BUS_SIZE and the ratio is >= 2.
    localparam int unsigned PARAM_WR_DAT_CYC_NUM = MEM_BYTES / BUS_BYTES;

    localparam int unsigned CNT_W = $clog2(PARAM_WR_DAT_CYC_NUM); // beat index width
    localparam int unsigned NZ_W  = $clog2(MEM_BYTES + 1);        // chunk nonzero count width
    localparam int unsigned SC_W  = $clog2(BUS_BYTES + 1);        // slice nonzero count width
    localparam int unsigned AW    = $clog2(MEM_BYTES);            // packed byte address width

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPack = 2'd1,
        StSend = 2'd2
    } state_e;

endpackage

// File: rtl/dat_chunk_slice_pack.sv
// Combinational slice analysis: per-byte nonzero flag, exclusive prefix count of
// nonzero bytes below each position (its offset inside the packed run) and the
// slice total.

module dat_chunk_slice_pack
    import dat_chunk_tx_pkg::*;
(
    input  logic [BUS_BYTES-1:0][7:0]     slice_i,
    output logic [BUS_BYTES-1:0]          nz_o,
    output logic [BUS_BYTES-1:0][SC_W-1:0] pfx_o,
    output logic [SC_W-1:0]               cnt_o
);

    logic [BUS_BYTES-1:0] nz;
    logic [SC_W-1:0]      run;

    // Ripple prefix popcount across the slice.
    always_comb begin
        nz    = '0;
        pfx_o = '0;
        run   = '0;
        for (int b = 0; b < BUS_BYTES; b++) begin
            nz[b]    = (slice_i[b] != 8'h00);
            pfx_o[b] = run;
            run      = run + SC_W'(nz[b]);
        end
        nz_o  = nz;
        cnt_o = run;
    end

endmodule

// File: rtl/dat_chunk_tx.sv
// Sparse chunk transmitter: accepts a dense MEM_SIZE-byte chunk, builds its
// sparsemap and a packed array of the nonzero bytes one bus slice per cycle,
// then streams both out as PARAM_WR_DAT_CYC_NUM registered write beats.
// Build option DAT_CHUNK_TX_DBUF_EN: ping-pong packed buffers so packing of the
// next chunk overlaps sending of the current one (gapless back-to-back beats).

module dat_chunk_tx
    import dat_chunk_tx_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [MEM_BYTES-1:0][7:0]     ld_dat_i,
    input  logic                          ld_valid_i,
    output logic                          ld_ready_o,
    output logic [BUS_BYTES-1:0]          wr_sparsemap_o,
    output logic [BUS_BYTES-1:0][7:0]     wr_nonzero_data_o,
    output logic                          wr_valid_o,
    output logic [CNT_W-1:0]              wr_count_o,
    output logic [NZ_W-1:0]               nz_cnt_o,
    output logic                          done_o
);

`ifdef DAT_CHUNK_TX_DBUF_EN
    localparam int unsigned NumBuf = 2;
    localparam state_e PackDoneSt = StIdle;  // sender runs independently
`else
    localparam int unsigned NumBuf = 1;
    localparam state_e PackDoneSt = StSend;
`endif
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(PARAM_WR_DAT_CYC_NUM - 1);

    state_e                     st_q, st_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [MEM_BYTES-1:0][7:0]  dat_q, dat_d;
    logic [NZ_W-1:0]            acc_q, acc_d;
    logic [MEM_BYTES-1:0][7:0]  pk_q [NumBuf];
    logic [MEM_BYTES-1:0][7:0]  pk_d [NumBuf];
    logic [MEM_BYTES-1:0]       sm_q [NumBuf];
    logic [MEM_BYTES-1:0]       sm_d [NumBuf];

    logic                       wr_valid_q, wr_valid_d;
    logic [CNT_W-1:0]           wr_count_q, wr_count_d;
    logic [BUS_BYTES-1:0]       wr_sm_q, wr_sm_d;
    logic [BUS_BYTES-1:0][7:0]  wr_dat_q, wr_dat_d;
    logic [NZ_W-1:0]            nz_q, nz_d;
    logic                       done_q, done_d;

    logic                       pk_sel, send_sel, new_sel;
    logic                       accept, pack_last, last_beat;
    logic [NZ_W-1:0]            acc_fin;
    logic [AW-1:0]              idx;
    logic [CNT_W-1:0]           beat;

    logic [BUS_BYTES-1:0][7:0]     slice;
    logic [BUS_BYTES-1:0]          sl_nz;
    logic [BUS_BYTES-1:0][SC_W-1:0] sl_pfx;
    logic [SC_W-1:0]               sl_cnt;

    assign slice     = dat_q[int'(cnt_q) * BUS_BYTES +: BUS_BYTES];
    assign pack_last = (st_q == StPack) && (cnt_q == LastCnt);
    assign last_beat = wr_valid_q && (wr_count_q == LastCnt);
    assign acc_fin   = acc_q + NZ_W'(sl_cnt);
    assign accept    = ld_valid_i && ld_ready_o;

    dat_chunk_slice_pack u_slice_pack (
        .slice_i (slice),
        .nz_o    (sl_nz),
        .pfx_o   (sl_pfx),
        .cnt_o   (sl_cnt)
    );

`ifdef DAT_CHUNK_TX_DBUF_EN
    logic       pk_sel_q, pk_sel_d, send_sel_q, send_sel_d;
    logic [1:0] full_q, full_d;  // buffer holds a chunk being packed, waiting or sent

    // Packer may take a new chunk in its last slice cycle so packing stays back-to-back.
    assign ld_ready_o = ((st_q == StIdle) || pack_last) && !(&full_q);
    assign new_sel    = full_q[0];
    assign pk_sel     = pk_sel_q;
    assign send_sel   = send_sel_q;

    // Ping-pong buffer bookkeeping.
    always_comb begin
        pk_sel_d   = accept ? new_sel : pk_sel_q;
        send_sel_d = pack_last ? pk_sel_q : send_sel_q;
        full_d     = full_q;
        if (last_beat) full_d[send_sel_q] = 1'b0;
        if (accept)    full_d[new_sel]    = 1'b1;
    end

    // Buffer selection state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pk_sel_q   <= 1'b0;
            send_sel_q <= 1'b0;
            full_q     <= '0;
        end else begin
            pk_sel_q   <= pk_sel_d;
            send_sel_q <= send_sel_d;
            full_q     <= full_d;
        end
    end
`else
    assign ld_ready_o = (st_q == StIdle);
    assign new_sel    = 1'b0;
    assign pk_sel     = 1'b0;
    assign send_sel   = 1'b0;
`endif

    // FSM, input capture and slice-by-slice scatter into the packed buffer.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        dat_d = dat_q;
        acc_d = acc_q;
        pk_d  = pk_q;
        sm_d  = sm_q;
        idx   = '0;
        if (st_q == StPack) begin
            for (int b = 0; b < BUS_BYTES; b++) begin
                if (sl_nz[b]) begin
                    idx = AW'(acc_q + NZ_W'(sl_pfx[b]));
                    pk_d[pk_sel][idx] = slice[b];
                end
            end
            sm_d[pk_sel][int'(cnt_q) * BUS_BYTES +: BUS_BYTES] = sl_nz;
            acc_d = acc_fin;
            cnt_d = cnt_q + CNT_W'(1);
            if (pack_last) begin
                st_d  = PackDoneSt;
                cnt_d = '0;
            end
        end else if ((st_q == StSend) && last_beat) begin
            st_d = StIdle;
        end
        if (accept) begin
            dat_d        = ld_dat_i;
            st_d         = StPack;
            cnt_d        = '0;
            acc_d        = '0;
            pk_d[new_sel] = '0;
            sm_d[new_sel] = '0;
        end
    end

    // Beat generator; beat 0 comes from next-state buffers so it lands right after packing.
    always_comb begin
        wr_valid_d = 1'b0;
        wr_count_d = '0;
        wr_sm_d    = '0;
        wr_dat_d   = '0;
        nz_d       = '0;
        done_d     = 1'b0;
        beat       = '0;
        if (pack_last) begin
            wr_valid_d = 1'b1;
            wr_sm_d    = sm_d[pk_sel][BUS_BYTES-1:0];
            wr_dat_d   = pk_d[pk_sel][BUS_BYTES-1:0];
            nz_d       = acc_fin;
        end else if (wr_valid_q && !last_beat) begin
            beat       = wr_count_q + CNT_W'(1);
            wr_valid_d = 1'b1;
            wr_count_d = beat;
            wr_sm_d    = sm_q[send_sel][int'(beat) * BUS_BYTES +: BUS_BYTES];
            wr_dat_d   = pk_q[send_sel][int'(beat) * BUS_BYTES +: BUS_BYTES];
            nz_d       = nz_q;
            done_d     = (beat == LastCnt);
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q       <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_count_q <= '0;
            wr_sm_q    <= '0;
            wr_dat_q   <= '0;
            nz_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            wr_valid_q <= wr_valid_d;
            wr_count_q <= wr_count_d;
            wr_sm_q    <= wr_sm_d;
            wr_dat_q   <= wr_dat_d;
            nz_q       <= nz_d;
            done_q     <= done_d;
        end
    end

    // Datapath storage; contents are cleared on every accept, so no reset is needed.
    always_ff @(posedge clk_i) begin
        dat_q <= dat_d;
        pk_q  <= pk_d;
        sm_q  <= sm_d;
    end

    assign wr_valid_o        = wr_valid_q;
    assign wr_count_o        = wr_count_q;
    assign wr_sparsemap_o    = wr_sm_q;
    assign wr_nonzero_data_o = wr_dat_q;
    assign nz_cnt_o          = nz_q;
    assign done_o            = done_q;

endmodule

// File: tb/tb_dat_chunk_tx.sv
// Directed self-checking bench for dat_chunk_tx (serial build; back-to-back
// streaming checks are added when DAT_CHUNK_TX_DBUF_EN is defined).

module tb_dat_chunk_tx;
    import dat_chunk_tx_pkg::*;

    localparam int N = PARAM_WR_DAT_CYC_NUM;

    logic                      clk;
    logic                      rst;
    logic [MEM_BYTES-1:0][7:0] ld_dat;
    logic                      ld_valid;
    logic                      ld_ready_o;
    logic [BUS_BYTES-1:0]      wr_sparsemap_o;
    logic [BUS_BYTES-1:0][7:0] wr_nonzero_data_o;
    logic                      wr_valid_o;
    logic [CNT_W-1:0]          wr_count_o;
    logic [NZ_W-1:0]           nz_cnt_o;
    logic                      done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [MEM_BYTES-1:0][7:0] c_a, c_b;
    int                        w;

    dat_chunk_tx u_dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ld_dat_i          (ld_dat),
        .ld_valid_i        (ld_valid),
        .ld_ready_o        (ld_ready_o),
        .wr_sparsemap_o    (wr_sparsemap_o),
        .wr_nonzero_data_o (wr_nonzero_data_o),
        .wr_valid_o        (wr_valid_o),
        .wr_count_o        (wr_count_o),
        .nz_cnt_o          (nz_cnt_o),
        .done_o            (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [BUS_BYTES-1:0] sm_exp,
                            input logic [BUS_BYTES-1:0][7:0] d_exp);
        int first;
        n_cmp++;
        assert (wr_sparsemap_o === sm_exp) else begin
            n_bad++;
            $error("FAIL %s sparsemap: observed %h expected %h", tag, wr_sparsemap_o, sm_exp);
        end
        first = 0;
        for (int b = BUS_BYTES - 1; b >= 0; b--)
            if (wr_nonzero_data_o[b] !== d_exp[b]) first = b;
        n_cmp++;
        assert (wr_nonzero_data_o === d_exp) else begin
            n_bad++;
            $error("FAIL %s data: byte %0d observed %h expected %h", tag, first,
                   wr_nonzero_data_o[first], d_exp[first]);
        end
    endtask

    // Reference compaction: n-th nonzero byte (ascending k) goes to packed index n-1.
    task automatic model(input logic [MEM_BYTES-1:0][7:0] d, output logic [MEM_BYTES-1:0] sm,
                         output logic [MEM_BYTES-1:0][7:0] pk, output int nz);
        sm = '0;
        pk = '0;
        nz = 0;
        for (int k = 0; k < MEM_BYTES; k++) begin
            if (d[k] != 8'h00) begin
                sm[k]  = 1'b1;
                pk[nz] = d[k];
                nz++;
            end
        end
    endtask

    task automatic rand_chunk(output logic [MEM_BYTES-1:0][7:0] d);
        for (int k = 0; k < MEM_BYTES; k++)
            d[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    endtask

    // Offer one chunk, then check PACK quiet cycles and all N beats; returns in the
    // cycle after the last beat. 'hold' keeps ld_valid_i high with d_after on the bus.
    task automatic run_chunk(input string name, input logic [MEM_BYTES-1:0][7:0] d,
                             input bit hold, input logic [MEM_BYTES-1:0][7:0] d_after,
                             output int waited);
        logic [MEM_BYTES-1:0]      esm;
        logic [MEM_BYTES-1:0][7:0] epk;
        int                        enz;
        model(d, esm, epk, enz);
        ld_dat   = d;
        ld_valid = 1'b1;
        waited   = 0;
        while (ld_ready_o !== 1'b1 && waited < 50) begin
            tick;
            waited++;
        end
        chk({name, " accept_in_time"}, 32'(waited < 50), 1);
        tick;
        ld_valid = hold;
        ld_dat   = d_after;
        for (int c = 1; c <= N; c++) begin
            chk({name, " pack_valid"}, wr_valid_o, 0);
            chk({name, " pack_count"}, wr_count_o, 0);
`ifndef DAT_CHUNK_TX_DBUF_EN
            chk({name, " pack_ready"}, ld_ready_o, 0);
`endif
            tick;
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s b%0d valid", name, i), wr_valid_o, 1);
            chk($sformatf("%s b%0d count", name, i), wr_count_o, i);
            chk($sformatf("%s b%0d nz", name, i), nz_cnt_o, enz);
            chk($sformatf("%s b%0d done", name, i), done_o, 32'(i == N - 1));
`ifndef DAT_CHUNK_TX_DBUF_EN
            chk($sformatf("%s b%0d ready", name, i), ld_ready_o, 0);
`endif
            chk_beat($sformatf("%s b%0d", name, i), esm[i * BUS_BYTES +: BUS_BYTES],
                     epk[i * BUS_BYTES +: BUS_BYTES]);
            tick;
        end
        chk({name, " post_valid"}, wr_valid_o, 0);
        chk({name, " post_done"}, done_o, 0);
        chk({name, " post_count"}, wr_count_o, 0);
    endtask

    initial begin
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_dat   = '0;
        tick;
        tick;
        chk("rst valid", wr_valid_o, 0);
        chk("rst done", done_o, 0);
        chk("rst count", wr_count_o, 0);
        chk("rst nz", nz_cnt_o, 0);
        chk_beat("rst", '0, '0);
        rst = 1'b0;
        tick;
        chk("rst ready", ld_ready_o, 1);

        // All-zero chunk.
        c_a = '0;
        run_chunk("zero", c_a, 1'b0, '0, w);

        // All-nonzero chunk: packed data equals input, nz = MEM_SIZE.
        for (int k = 0; k < MEM_BYTES; k++) c_a[k] = 8'((k % 255) + 1);
        run_chunk("full", c_a, 1'b0, '0, w);

        // Only first and last byte nonzero.
        c_a = '0;
        c_a[0] = 8'hAA;
        c_a[MEM_BYTES - 1] = 8'h55;
        run_chunk("ends", c_a, 1'b0, '0, w);

        // Only the last slice nonzero: beat 0 is filled by the final packing cycle.
        c_a = '0;
        for (int k = MEM_BYTES - BUS_BYTES; k < MEM_BYTES; k++) c_a[k] = 8'h80 | 8'(k & 127);
        run_chunk("tail", c_a, 1'b0, '0, w);

`ifndef DAT_CHUNK_TX_DBUF_EN
        // ld_valid_i held through PACK/SEND with new data: taken only once back in IDLE.
        rand_chunk(c_a);
        rand_chunk(c_b);
        run_chunk("holdA", c_a, 1'b1, c_b, w);
        chk("hold ready_after_send", ld_ready_o, 1);
        run_chunk("holdB", c_b, 1'b0, '0, w);
        chk("hold no_wait", w, 0);
`endif

        // Reset during beat 1 discards the chunk.
        rand_chunk(c_a);
        ld_dat   = c_a;
        ld_valid = 1'b1;
        w = 0;
        while (ld_ready_o !== 1'b1 && w < 50) begin
            tick;
            w++;
        end
        tick;
        ld_valid = 1'b0;
        repeat (N + 1) tick;
        chk("rstsend beat1 valid", wr_valid_o, 1);
        chk("rstsend beat1 count", wr_count_o, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rstsend valid", wr_valid_o, 0);
        chk("rstsend done", done_o, 0);
        chk("rstsend ready", ld_ready_o, 1);
        chk("rstsend nz", nz_cnt_o, 0);
        for (int c = 0; c < N + 2; c++) begin
            tick;
            chk("rstsend quiet valid", wr_valid_o, 0);
            chk("rstsend quiet done", done_o, 0);
        end

        // A random 25%-dense chunk through the normal path.
        rand_chunk(c_a);
        run_chunk("rand", c_a, 1'b0, '0, w);

`ifdef DAT_CHUNK_TX_DBUF_EN
        begin : dbuf_b2b
            logic [MEM_BYTES-1:0]      rx_sm [2];
            logic [MEM_BYTES-1:0][7:0] rx_pk [2];
            logic [MEM_BYTES-1:0]      esm;
            logic [MEM_BYTES-1:0][7:0] epk, rec;
            int                        enz [2];
            int                        ch, bt, ptr, bad;
            rand_chunk(c_a);
            rand_chunk(c_b);
            model(c_a, esm, epk, enz[0]);
            model(c_b, esm, epk, enz[1]);
            ld_dat   = c_a;
            ld_valid = 1'b1;
            w = 0;
            while (ld_ready_o !== 1'b1 && w < 50) begin
                tick;
                w++;
            end
            tick;
            ld_dat = c_b;
            w = 0;
            while (ld_ready_o !== 1'b1 && w < 20) begin
                tick;
                w++;
            end
            chk("b2b second_accept_wait", w, N - 1);
            tick;
            ld_valid = 1'b0;
            for (int i = 0; i < 2 * N; i++) begin
                ch = i / N;
                bt = i % N;
                chk($sformatf("b2b %0d valid", i), wr_valid_o, 1);
                chk($sformatf("b2b %0d count", i), wr_count_o, bt);
                chk($sformatf("b2b %0d done", i), done_o, 32'(bt == N - 1));
                chk($sformatf("b2b %0d nz", i), nz_cnt_o, enz[ch]);
                rx_sm[ch][bt * BUS_BYTES +: BUS_BYTES] = wr_sparsemap_o;
                rx_pk[ch][bt * BUS_BYTES +: BUS_BYTES] = wr_nonzero_data_o;
                tick;
            end
            chk("b2b post_valid", wr_valid_o, 0);
            for (int c = 0; c < 2; c++) begin
                ptr = 0;
                bad = 0;
                for (int k = 0; k < MEM_BYTES; k++) begin
                    if (rx_sm[c][k] && ptr < MEM_BYTES) begin
                        rec[k] = rx_pk[c][ptr];
                        ptr++;
                    end else begin
                        rec[k] = 8'h00;
                    end
                end
                for (int k = 0; k < MEM_BYTES; k++)
                    if (rec[k] !== ((c == 0) ? c_a[k] : c_b[k])) bad++;
                chk($sformatf("b2b chunk%0d reconstruct_bad_bytes", c), bad, 0);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
